uart_tx: RTL and testbench

- UART transmitter that drains the UART transmit FIFO.
- Sits between the FIFO's read side and the serial `tx` pin.
- Waits for the FIFO to be non-empty, captures the head word, pops it, then serialises one frame: start bit, data bits LSB first, optional parity bit, stop bit.
- Counterpart of the receive path; consumes the same FIFO read interface (registered `q`, `read_ack` pop).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_if.sv | 15 +
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame/baud constants,
// used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned UartDataBits   = 8;
  localparam int unsigned UartClksPerBit = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read-side interface consumed by the UART transmitter: registered head data,
// empty flag and a one-cycle pop strobe.
interface uart_tx_if #(
  parameter int unsigned DataBitsSize = uart_pkg::UartDataBits
);

  logic [DataBitsSize-1:0] fifo_q;
  logic                    fifo_empty;
  logic                    fifo_read_ack;

  // master = FIFO side, slave = transmitter side
  modport master (output fifo_q, output fifo_empty, input fifo_read_ack);
  modport slave  (input fifo_q, input fifo_empty, output fifo_read_ack);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..ClksPerBit-1 and raises bit_done while the count sits
// on its last value; clear (or a finished period) restarts the count at zero.
module uart_baud_gen #(
  parameter int unsigned ClksPerBit = uart_pkg::UartClksPerBit
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CntW = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;

  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CntW'(1);
    if (clear || bit_done) cnt_next = '0;
  end

  // bit_done is registered from the next count so it is high exactly when cnt is last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_done <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      bit_done <= (cnt_next == CntW'(ClksPerBit - 1));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining the TX FIFO: start bit, LSB-first data, optional even
// parity (UART_TX_PARITY_EN), stop bit. tx, busy and the FIFO pop are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DataBitsSize = UartDataBits,
  parameter int unsigned ClksPerBit   = UartClksPerBit
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  uart_tx_if.slave   fifo,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned BitCntW = (DataBitsSize > 1) ? $clog2(DataBitsSize) : 1;

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_FETCH  = 3'(FETCH);
  localparam logic [2:0] S_LOAD   = 3'(LOAD);
  localparam logic [2:0] S_START  = 3'(START);
  localparam logic [2:0] S_DATA   = 3'(DATA);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(PARITY);
`endif
  localparam logic [2:0] S_STOP   = 3'(STOP);

  logic [2:0]              state, state_next;
  logic [DataBitsSize-1:0] shift, shift_next;
  logic [BitCntW-1:0]      bit_cnt, bit_cnt_next;
  logic                    tx_next;
  logic                    ack_next;
  logic                    baud_clear;
  logic                    bit_done;
`ifdef UART_TX_PARITY_EN
  logic                    parity, parity_next;
`endif

  uart_baud_gen #(.ClksPerBit(ClksPerBit)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (baud_clear),
    .bit_done (bit_done)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    ack_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif
    case (state)
      S_IDLE:  if (tx_en && !fifo.fifo_empty) state_next = S_FETCH;
      S_FETCH: begin
        // pop is issued for the LOAD cycle only if the head is still there
        if (fifo.fifo_empty) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_LOAD;
          ack_next   = 1'b1;
        end
      end
      S_LOAD: begin
        shift_next  = fifo.fifo_q;
`ifdef UART_TX_PARITY_EN
        parity_next = ^fifo.fifo_q;
`endif
        state_next  = S_START;
      end
      S_START: if (bit_done) begin
        state_next   = S_DATA;
        bit_cnt_next = '0;
      end
      S_DATA: if (bit_done) begin
        shift_next = shift >> 1;
        if (bit_cnt == BitCntW'(DataBitsSize - 1)) begin
          bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
          state_next   = S_PARITY;
`else
          state_next   = S_STOP;
`endif
        end else begin
          bit_cnt_next = bit_cnt + BitCntW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_next = S_STOP;
`endif
      S_STOP:  if (bit_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // line level for the cycle after this edge
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = parity_next;
`endif
      default:  tx_next = 1'b1;
    endcase

    baud_clear = (state_next != state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      shift              <= '0;
      bit_cnt            <= '0;
      tx                 <= 1'b1;
      busy               <= 1'b0;
      fifo.fifo_read_ack <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity             <= 1'b0;
`endif
    end else begin
      state              <= state_next;
      shift              <= shift_next;
      bit_cnt            <= bit_cnt_next;
      tx                 <= tx_next;
      busy               <= (state_next != S_IDLE);
      fifo.fifo_read_ack <= ack_next;
`ifdef UART_TX_PARITY_EN
      parity             <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a FIFO model feeds the DUT, written bytes go to a
// scoreboard and are compared bit by bit against the serial line.
module tb_uart_tx;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Db  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBits = 11;
`else
  localparam int unsigned NBits = 10;
`endif
  localparam int MaxWait = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic tx;
  logic busy;

  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fq[$];
  logic [7:0] sb[$];
  int acks      = 0;
  int bad_acks  = 0;
  int errors    = 0;
  int checks    = 0;

  uart_tx_if #(.DataBitsSize(Db)) fif ();

  uart_tx #(.DataBitsSize(Db), .ClksPerBit(Cpb)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_en (tx_en),
    .fifo  (fif),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: registered head data, empty flag updated on the write/pop edge
  always @(posedge clk) begin
    fif.fifo_q <= (fq.size() > 0) ? fq[0] : 8'h00;
    if (fif.fifo_read_ack === 1'b1) begin
      acks <= acks + 1;
      if (fif.fifo_empty === 1'b1) bad_acks <= bad_acks + 1;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    if (wr_en) fq.push_back(wr_data);
    fif.fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    sb.push_back(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx !== 1'b0 && waited < MaxWait);
  endtask

  // Expects the start bit 3 sample cycles after the call; drop_bit >= 0 drops tx_en
  // at the start of that frame bit.
  task automatic check_frame(input string tag, input int drop_bit);
    int w;
    logic [7:0] d;
    logic [NBits-1:0] bits;
    wait_start(w);
    chk({tag, " latency"}, 32'(w), 32'd3);
    if (w >= MaxWait || sb.size() == 0) return;
    d = sb.pop_front();
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^d, d, 1'b0};
`else
    bits = {1'b1, d, 1'b0};
`endif
    for (int i = 0; i < int'(NBits); i++) begin
      for (int c = 0; c < int'(Cpb); c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (c == 0 && i == drop_bit) tx_en = 1'b0;
        chk($sformatf("%s bit%0d c%0d", tag, i, c), 32'(tx), 32'(bits[i]));
        if (c == 0) chk($sformatf("%s busy bit%0d", tag, i), 32'(busy), 32'd1);
      end
    end
    @(negedge clk);
    chk({tag, " idle tx"}, 32'(tx), 32'd1);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int a0;
    int w;
    logic low_seen;

    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ack", 32'(fif.fifo_read_ack), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte
    tx_en = 1'b1;
    a0 = acks;
    write_byte(8'hA5);
    check_frame("A5", -1);
    chk("A5 pops", 32'(acks - a0), 32'd1);

    // two queued bytes, back to back
    tx_en = 1'b0;
    a0 = acks;
    write_byte(8'h00);
    write_byte(8'hFF);
    @(negedge clk);
    tx_en = 1'b1;
    check_frame("00", -1);
    check_frame("FF", -1);
    chk("00/FF pops", 32'(acks - a0), 32'd2);

    // tx_en low holds the line idle
    tx_en = 1'b0;
    a0 = acks;
    write_byte(8'h3C);
    low_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("3C held idle", 32'(low_seen), 32'd0);
    chk("3C no pop", 32'(acks - a0), 32'd0);
    tx_en = 1'b1;
    check_frame("3C", -1);
    chk("3C pops", 32'(acks - a0), 32'd1);

    // tx_en dropped mid-frame: frame completes, next queued byte waits
    tx_en = 1'b0;
    a0 = acks;
    write_byte(8'h55);
    write_byte(8'h81);
    @(negedge clk);
    tx_en = 1'b1;
    check_frame("55", 3);
    low_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
    end
    chk("55 no next frame", 32'(low_seen), 32'd0);
    chk("55 pops", 32'(acks - a0), 32'd1);
    tx_en = 1'b1;
    check_frame("81", -1);
    chk("81 pops", 32'(acks - a0), 32'd2);

    // parity-sensitive bytes (odd and even popcount)
    write_byte(8'h07);
    check_frame("07", -1);
    write_byte(8'h03);
    check_frame("03", -1);

    // reset mid-frame
    a0 = acks;
    write_byte(8'h5A);
    wait_start(w);
    chk("5A latency", 32'(w), 32'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst tx", 32'(tx), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ack", 32'(fif.fifo_read_ack), 32'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    low_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    chk("midrst line idle", 32'(low_seen), 32'd0);
    chk("midrst single pop", 32'(acks - a0), 32'd1);

    chk("ack while empty", 32'(bad_acks), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
